// File: rtl/flags_unit_if.sv
// ---------------------------------------------------------------------------
// flags_unit_if
// Bundles the ALU-side and control-side signals of flags_unit so the block
// can be dropped between the ALU and the branch logic with a single port.
//
// Parameters
//   WIDTH : ALU result width in bits (>= 2)
//   DEPTH : number of flag save-stack entries (>= 1)
//
// Signals (direction seen from the master, i.e. the ALU/control side)
//   alu_result   out WIDTH  ALU result
//   alu_carry    out 1      ALU carry-out
//   alu_overflow out 1      ALU signed overflow
//   set_flags    out 1      update the flag register this cycle
//   flag_mask    out 4      per-flag update enable {N,Z,C,V}
//   push         out 1      save current flags onto the stack
//   pop          out 1      restore flags from the stack top
//   clear_sticky out 1      clear the sticky flags
//   cond         out 4      condition code to evaluate
//   flags        in  4      registered {N,Z,C,V}
//   sticky       in  4      accumulated flags since last clear
//   cond_true    in  1      cond evaluated against flags
//   depth_count  in  CW     number of valid stack entries
//   stack_full   in  1      depth_count == DEPTH
//   stack_empty  in  1      depth_count == 0
//   err          in  1      sticky stack overflow/underflow error
// ---------------------------------------------------------------------------
interface flags_unit_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;
  logic             alu_overflow;
  logic             set_flags;
  logic [3:0]       flag_mask;
  logic             push;
  logic             pop;
  logic             clear_sticky;
  logic [3:0]       cond;

  logic [3:0]       flags;
  logic [3:0]       sticky;
  logic             cond_true;
  logic [CW-1:0]    depth_count;
  logic             stack_full;
  logic             stack_empty;
  logic             err;

  modport master (
    output alu_result, alu_carry, alu_overflow, set_flags, flag_mask,
           push, pop, clear_sticky, cond,
    input  flags, sticky, cond_true, depth_count, stack_full, stack_empty, err
  );

  modport slave (
    input  alu_result, alu_carry, alu_overflow, set_flags, flag_mask,
           push, pop, clear_sticky, cond,
    output flags, sticky, cond_true, depth_count, stack_full, stack_empty, err
  );
endinterface

// File: rtl/flags_unit.sv
// ---------------------------------------------------------------------------
// flags_unit
// Derives N/Z/C/V from an ALU result, holds them in a masked flag register,
// accumulates sticky flags, keeps a LIFO save/restore stack of flag values
// and evaluates an ARM-style 4-bit condition code against the current flags.
//
// Parameters
//   WIDTH : ALU result width in bits (>= 2)
//   DEPTH : flag save-stack entries (>= 1)
//
// Ports
//   clk  in  rising-edge clock
//   rst  in  asynchronous active-high reset
//   bus  flags_unit_if.slave - ALU inputs, control requests and all status
//        outputs (flags, sticky, cond_true, depth_count, stack_full,
//        stack_empty, err)
// ---------------------------------------------------------------------------
module flags_unit #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  flags_unit_if.slave  bus
);

  localparam int CW = $clog2(DEPTH + 1);
  // Storage is rounded up to a power of two so depth_count can index it
  // directly; the slots at and above DEPTH are never written.
  localparam int SLOTS = 1 << CW;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  logic [3:0]    r_flags;
  logic [3:0]    r_sticky;
  logic [CW-1:0] r_depth;
  logic          r_full;
  logic          r_empty;
  logic          r_err;
  logic [3:0]    r_stack [0:SLOTS-1];

  logic [3:0]    w_cand;
  logic [3:0]    w_maskedCand;
  logic          w_doPush;
  logic          w_doPop;
  logic          w_pushOk;
  logic          w_popOk;
  logic          w_setEff;
  logic [CW-1:0] w_topIdx;
  logic [CW-1:0] w_depthNext;
  logic          w_condTrue;
  logic          w_n;
  logic          w_z;
  logic          w_c;
  logic          w_v;

  // Candidate flags straight from the ALU, ordered {N,Z,C,V}.
  assign w_cand = {bus.alu_result[WIDTH-1], (bus.alu_result == '0),
                   bus.alu_carry, bus.alu_overflow};
  assign w_maskedCand = w_cand & bus.flag_mask;

  // A simultaneous push and pop cancels out: neither touches the stack.
  assign w_doPush = bus.push & ~bus.pop;
  assign w_doPop  = bus.pop & ~bus.push;
  assign w_pushOk = w_doPush & ~r_full;
  assign w_popOk  = w_doPop & ~r_empty;

  // A pop (even a failing one) takes priority over set_flags.
  assign w_setEff = bus.set_flags & ~w_doPop;

  assign w_topIdx = r_depth - CW'(1);

  // Next stack depth, shared by the counter and the full/empty registers.
  always_comb begin
    w_depthNext = r_depth;
    if (w_pushOk) begin
      w_depthNext = r_depth + CW'(1);
    end else if (w_popOk) begin
      w_depthNext = r_depth - CW'(1);
    end
  end

  // Flag register: restore from the stack on pop, otherwise masked update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flags <= 4'b0000;
    end else if (w_doPop) begin
      if (!r_empty) begin
        r_flags <= r_stack[w_topIdx];
      end
    end else if (bus.set_flags) begin
      r_flags <= (r_flags & ~bus.flag_mask) | w_maskedCand;
    end
  end

  // Sticky flags: a clear in the same cycle as an update keeps only the
  // freshly written bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sticky <= 4'b0000;
    end else if (bus.clear_sticky) begin
      r_sticky <= w_setEff ? w_maskedCand : 4'b0000;
    end else if (w_setEff) begin
      r_sticky <= r_sticky | w_maskedCand;
    end
  end

  // Stack occupancy and registered full/empty indications.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_depth <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      r_depth <= w_depthNext;
      r_full  <= (w_depthNext == DEPTH_CNT);
      r_empty <= (w_depthNext == '0);
    end
  end

  // Error latches on any rejected push or pop and only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if ((w_doPush && r_full) || (w_doPop && r_empty)) begin
      r_err <= 1'b1;
    end
  end

  // Stack storage needs no reset; the saved value is the flag register as
  // it was before any same-cycle update.
  always_ff @(posedge clk) begin
    if (w_pushOk) begin
      r_stack[r_depth] <= r_flags;
    end
  end

  assign w_n = r_flags[3];
  assign w_z = r_flags[2];
  assign w_c = r_flags[1];
  assign w_v = r_flags[0];

  // Condition decode works only on the registered flags, never on the
  // candidates, so it reflects an update one cycle after it is requested.
  always_comb begin
    w_condTrue = 1'b0;
    case (bus.cond)
      4'd0:  w_condTrue = w_z;
      4'd1:  w_condTrue = ~w_z;
      4'd2:  w_condTrue = w_c;
      4'd3:  w_condTrue = ~w_c;
      4'd4:  w_condTrue = w_n;
      4'd5:  w_condTrue = ~w_n;
      4'd6:  w_condTrue = w_v;
      4'd7:  w_condTrue = ~w_v;
      4'd8:  w_condTrue = w_c & ~w_z;
      4'd9:  w_condTrue = ~w_c | w_z;
      4'd10: w_condTrue = (w_n == w_v);
      4'd11: w_condTrue = (w_n != w_v);
      4'd12: w_condTrue = ~w_z & (w_n == w_v);
      4'd13: w_condTrue = w_z | (w_n != w_v);
      4'd14: w_condTrue = 1'b1;
      default: w_condTrue = 1'b0;
    endcase
  end

  assign bus.flags       = r_flags;
  assign bus.sticky      = r_sticky;
  assign bus.cond_true   = w_condTrue;
  assign bus.depth_count = r_depth;
  assign bus.stack_full  = r_full;
  assign bus.stack_empty = r_empty;
  assign bus.err         = r_err;

endmodule

// File: tb/tb_flags_unit.sv
// ---------------------------------------------------------------------------
// tb_flags_unit
// Self-checking bench for flags_unit (WIDTH=4, DEPTH=4): a table of
// condition-decode vectors, hand-written multi-cycle sequences for masking,
// sticky flags, stack overflow/underflow, simultaneous requests and an
// asynchronous reset, then randomized traffic against a reference model.
// ---------------------------------------------------------------------------
module tb_flags_unit;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  flags_unit_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  flags_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errorCount = 0;
  int checkCount = 0;

  // Reference model state: flags/sticky as plain nibbles, stack as a queue.
  logic [3:0] mFlags;
  logic [3:0] mSticky;
  logic       mErr;
  logic [3:0] mStack[$];

  typedef struct {
    logic [3:0] res;
    logic       c;
    logic       v;
    logic [3:0] cond;
    logic [3:0] expFlags;
    logic       expCond;
  } VecRow;

  VecRow vecs[17];

  function automatic logic evalCond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic modelReset();
    mFlags  = 4'b0000;
    mSticky = 4'b0000;
    mErr    = 1'b0;
    mStack.delete();
  endtask

  task automatic checkVal(input string name, input logic [7:0] act, input logic [7:0] exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of requests, advance the clock, step the model.
  task automatic applyStimulus(input logic [3:0] res, input logic c, input logic v,
                               input logic set, input logic [3:0] mask,
                               input logic psh, input logic pp, input logic clr,
                               input logic [3:0] cnd);
    logic [3:0] cand;
    logic [3:0] newFlags;
    bit doPush, doPop, setEff;
    bus.alu_result   = res;
    bus.alu_carry    = c;
    bus.alu_overflow = v;
    bus.set_flags    = set;
    bus.flag_mask    = mask;
    bus.push         = psh;
    bus.pop          = pp;
    bus.clear_sticky = clr;
    bus.cond         = cnd;
    @(posedge clk);
    cand   = {res[3], (res == 4'd0), c, v};
    doPush = psh && !pp;
    doPop  = pp && !psh;
    setEff = set && !doPop;
    newFlags = mFlags;
    if (doPop) begin
      if (mStack.size() > 0) newFlags = mStack.pop_back();
      else mErr = 1'b1;
    end else if (set) begin
      for (int b = 0; b < 4; b++) if (mask[b]) newFlags[b] = cand[b];
    end
    if (doPush) begin
      if (mStack.size() < DEPTH) mStack.push_back(mFlags);
      else mErr = 1'b1;
    end
    if (clr) mSticky = setEff ? (cand & mask) : 4'b0000;
    else if (setEff) mSticky = mSticky | (cand & mask);
    mFlags = newFlags;
    #1;
  endtask

  task automatic checkOutput();
    checkVal("flags",     {4'd0, bus.flags},       {4'd0, mFlags});
    checkVal("sticky",    {4'd0, bus.sticky},      {4'd0, mSticky});
    checkVal("depth",     8'(bus.depth_count),     8'(mStack.size()));
    checkVal("full",      {7'd0, bus.stack_full},  {7'd0, (mStack.size() == DEPTH)});
    checkVal("empty",     {7'd0, bus.stack_empty}, {7'd0, (mStack.size() == 0)});
    checkVal("err",       {7'd0, bus.err},         {7'd0, mErr});
    checkVal("cond_true", {7'd0, bus.cond_true},   {7'd0, evalCond(bus.cond, mFlags)});
  endtask

  task automatic idle();
    applyStimulus(4'd0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'd14);
  endtask

  initial begin
    // Condition decode vectors: every row writes all four flags.
    vecs[0]  = '{4'b0000, 1'b1, 1'b0, 4'd0,  4'b0110, 1'b1};
    vecs[1]  = '{4'b0000, 1'b1, 1'b0, 4'd8,  4'b0110, 1'b0};
    vecs[2]  = '{4'b1000, 1'b0, 1'b1, 4'd10, 4'b1001, 1'b1};
    vecs[3]  = '{4'b1000, 1'b0, 1'b1, 4'd11, 4'b1001, 1'b0};
    vecs[4]  = '{4'b0101, 1'b1, 1'b0, 4'd8,  4'b0010, 1'b1};
    vecs[5]  = '{4'b0101, 1'b0, 1'b1, 4'd12, 4'b0001, 1'b0};
    vecs[6]  = '{4'b1111, 1'b1, 1'b1, 4'd12, 4'b1011, 1'b1};
    vecs[7]  = '{4'b0000, 1'b0, 1'b1, 4'd13, 4'b0101, 1'b1};
    vecs[8]  = '{4'b0011, 1'b0, 1'b0, 4'd9,  4'b0000, 1'b1};
    vecs[9]  = '{4'b1100, 1'b0, 1'b0, 4'd4,  4'b1000, 1'b1};
    vecs[10] = '{4'b1100, 1'b0, 1'b0, 4'd5,  4'b1000, 1'b0};
    vecs[11] = '{4'b0001, 1'b1, 1'b0, 4'd2,  4'b0010, 1'b1};
    vecs[12] = '{4'b0001, 1'b1, 1'b0, 4'd3,  4'b0010, 1'b0};
    vecs[13] = '{4'b0001, 1'b0, 1'b0, 4'd15, 4'b0000, 1'b0};
    vecs[14] = '{4'b0001, 1'b0, 1'b0, 4'd14, 4'b0000, 1'b1};
    vecs[15] = '{4'b0110, 1'b0, 1'b1, 4'd7,  4'b0001, 1'b0};
    vecs[16] = '{4'b0000, 1'b0, 1'b0, 4'd1,  4'b0100, 1'b0};

    rst = 1'b1;
    bus.alu_result = '0; bus.alu_carry = 1'b0; bus.alu_overflow = 1'b0;
    bus.set_flags = 1'b0; bus.flag_mask = 4'h0; bus.push = 1'b0;
    bus.pop = 1'b0; bus.clear_sticky = 1'b0; bus.cond = 4'd1;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkVal("rst_flags", {4'd0, bus.flags}, 8'h00);
    checkVal("rst_ne", {7'd0, bus.cond_true}, 8'h01);
    rst = 1'b0;
    checkOutput();

    $display("[TB] condition table");
    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].res, vecs[i].c, vecs[i].v, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, vecs[i].cond);
      checkVal($sformatf("tbl%0d_flags", i), {4'd0, bus.flags}, {4'd0, vecs[i].expFlags});
      checkVal($sformatf("tbl%0d_cond", i), {7'd0, bus.cond_true}, {7'd0, vecs[i].expCond});
      checkOutput();
    end

    $display("[TB] masked update");
    applyStimulus(4'b1000, 1'b0, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 4'd10);
    checkVal("mask_pre", {4'd0, bus.flags}, 8'h09);
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 4'd2);
    checkVal("mask_post", {4'd0, bus.flags}, 8'h0B);
    checkOutput();

    $display("[TB] sticky");
    applyStimulus(4'd0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'd0);
    checkVal("sticky_clr", {4'd0, bus.sticky}, 8'h00);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 4'd0);
    applyStimulus(4'b0001, 1'b0, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 4'd0);
    checkVal("sticky_acc", {4'd0, bus.sticky}, 8'h05);
    applyStimulus(4'b0001, 1'b1, 1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b1, 4'd0);
    checkVal("sticky_clrset", {4'd0, bus.sticky}, 8'h02);
    checkOutput();

    $display("[TB] stack overflow and LIFO restore");
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 4'd0);
    applyStimulus(4'b1000, 1'b0, 1'b1, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0, 4'd0);
    checkVal("push1_flags", {4'd0, bus.flags}, 8'h09);
    applyStimulus(4'b0101, 1'b1, 1'b0, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0, 4'd0);
    applyStimulus(4'b1111, 1'b1, 1'b1, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0, 4'd0);
    applyStimulus(4'd0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'd0);
    checkVal("push4_full", {7'd0, bus.stack_full}, 8'h01);
    checkVal("push4_err", {7'd0, bus.err}, 8'h00);
    applyStimulus(4'd0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'd0);
    checkVal("push5_err", {7'd0, bus.err}, 8'h01);
    checkVal("push5_depth", 8'(bus.depth_count), 8'h04);
    applyStimulus(4'b0011, 1'b0, 1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 4'd0);
    checkVal("scratch_flags", {4'd0, bus.flags}, 8'h00);
    applyStimulus(4'd0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 4'd0);
    checkVal("pop1_D", {4'd0, bus.flags}, 8'h0B);
    applyStimulus(4'd0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 4'd0);
    checkVal("pop2_C", {4'd0, bus.flags}, 8'h02);
    applyStimulus(4'd0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 4'd0);
    checkVal("pop3_B", {4'd0, bus.flags}, 8'h09);
    applyStimulus(4'd0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 4'd0);
    checkVal("pop4_A", {4'd0, bus.flags}, 8'h06);
    checkVal("pop4_empty", {7'd0, bus.stack_empty}, 8'h01);
    applyStimulus(4'd0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 4'd0);
    checkVal("pop5_flags", {4'd0, bus.flags}, 8'h06);
    checkVal("pop5_empty", {7'd0, bus.stack_empty}, 8'h01);
    checkOutput();

    $display("[TB] simultaneous requests");
    applyStimulus(4'd0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'd0);
    applyStimulus(4'd0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'd0);
    applyStimulus(4'b0011, 1'b0, 1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 4'd0);
    applyStimulus(4'b0000, 1'b1, 1'b1, 1'b1, 4'hF, 1'b0, 1'b1, 1'b0, 4'd0);
    checkVal("popset_flags", {4'd0, bus.flags}, 8'h06);
    checkVal("popset_sticky", {4'd0, bus.sticky}, 8'h00);
    applyStimulus(4'd0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'd0);
    applyStimulus(4'b1000, 1'b0, 1'b0, 1'b1, 4'hF, 1'b1, 1'b1, 1'b0, 4'd0);
    checkVal("pushpop_depth", 8'(bus.depth_count), 8'h01);
    checkVal("pushpop_flags", {4'd0, bus.flags}, 8'h08);
    applyStimulus(4'd0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'd0);
    applyStimulus(4'd0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'd0);
    checkVal("pre_rst_depth", 8'(bus.depth_count), 8'h03);
    checkOutput();

    $display("[TB] asynchronous reset mid-operation");
    bus.push = 1'b0;
    bus.cond = 4'd1;
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    checkVal("arst_depth", 8'(bus.depth_count), 8'h00);
    checkVal("arst_flags", {4'd0, bus.flags}, 8'h00);
    checkVal("arst_sticky", {4'd0, bus.sticky}, 8'h00);
    checkVal("arst_empty", {7'd0, bus.stack_empty}, 8'h01);
    checkVal("arst_full", {7'd0, bus.stack_full}, 8'h00);
    checkVal("arst_err", {7'd0, bus.err}, 8'h00);
    checkVal("arst_ne", {7'd0, bus.cond_true}, 8'h01);
    bus.cond = 4'd14;
    #1;
    checkVal("arst_al", {7'd0, bus.cond_true}, 8'h01);
    bus.cond = 4'd0;
    #1;
    checkVal("arst_eq", {7'd0, bus.cond_true}, 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput();

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        #2;
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput();
        @(posedge clk);
        #1;
        rst = 1'b0;
      end
      applyStimulus(4'($urandom), 1'($urandom), 1'($urandom),
                    ($urandom_range(0, 3) != 0), 4'($urandom),
                    ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 7) == 0), 4'($urandom));
      checkOutput();
    end
    idle();
    checkOutput();

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
